// File: rtl/pipe_adder3_if.sv
// ---------------------------------------------------------------------------
// pipe_adder3_if
// Operand/result bundle for the pipelined three-operand adder.
//   in_valid / in_ready   : input handshake for one operand set
//   a, b, c               : unsigned operands, WIDTH bits each
//   sub                   : 0 -> a+b+c, 1 -> a+b-c
//   out_valid / out_ready : output handshake for one result
//   foo                   : result, WIDTH+2 bits, two's complement
// master = operand source / result sink; slave = the adder.
// ---------------------------------------------------------------------------
interface pipe_adder3_if #(
   parameter int WIDTH = 8
);
   logic               in_valid;
   logic               in_ready;
   logic [WIDTH-1:0]   a;
   logic [WIDTH-1:0]   b;
   logic [WIDTH-1:0]   c;
   logic               sub;
   logic               out_valid;
   logic               out_ready;
   logic [WIDTH+1:0]   foo;

   modport master (
      output in_valid, a, b, c, sub, out_ready,
      input  in_ready, out_valid, foo
   );

   modport slave (
      input  in_valid, a, b, c, sub, out_ready,
      output in_ready, out_valid, foo
   );
endinterface

// File: rtl/pipe_adder3.sv
// ---------------------------------------------------------------------------
// pipe_adder3
// Pipelined a+b+c / a+b-c adder with valid/ready flow control.
// Stage 0 registers a carry-save reduction of the three operands; stages
// 1..NSEG each resolve one CHUNK-bit ripple segment (LSB first) and pass the
// carry on. Latency from presentation to result is NSEG+1 cycles.
//   clk   : sole clock, rising edge
//   reset : synchronous, active-high; clears every stage valid bit
//   bus   : pipe_adder3_if.slave (operands in, result out)
// ---------------------------------------------------------------------------
module pipe_adder3 #(
   parameter int WIDTH = 8,
   parameter int CHUNK = 4
) (
   input  logic         clk,
   input  logic         reset,
   pipe_adder3_if.slave bus
);
   localparam int NSEG = WIDTH / CHUNK;
   localparam int W2   = WIDTH + 2;

   // Per-stage state. Index 0 is the carry-save stage, index NSEG is output.
   // s/k are the carry-save sum and carry vectors, res holds the bits
   // resolved so far, cy is the carry into the next unresolved segment.
   logic [W2-1:0] s_reg   [0:NSEG];
   logic [W2-1:0] k_reg   [0:NSEG];
   logic [W2-1:0] res_reg [0:NSEG];
   logic          cy_reg  [0:NSEG];
   logic [NSEG:0] vld_reg;
   logic [NSEG:0] adv;
   logic          load0;

   // ---------------------------------------------------------------------
   // Flow control. A stage advances when it holds an item and either the
   // output is being taken or some later stage is empty; with no bubble
   // anywhere above, everything behind a stalled output stays put. This
   // form avoids a ripple through the adv vector itself.
   // ---------------------------------------------------------------------
   genvar gi;
   generate
      for (gi = 0; gi <= NSEG; gi++) begin : g_adv
         if (gi == NSEG) begin : g_last
            assign adv[gi] = vld_reg[gi] & bus.out_ready;
         end else begin : g_mid
            assign adv[gi] = vld_reg[gi] & (bus.out_ready | ~(&vld_reg[NSEG:gi+1]));
         end
      end
   endgenerate

   assign bus.in_ready  = ~vld_reg[0] | adv[0];
   assign load0         = bus.in_valid & bus.in_ready;
   assign bus.out_valid = vld_reg[NSEG];
   assign bus.foo       = res_reg[NSEG];

   always_ff @(posedge clk) begin
      if (reset) begin
         vld_reg <= '0;
      end else begin
         vld_reg[0] <= load0 | (vld_reg[0] & ~adv[0]);
         for (int i = 1; i <= NSEG; i++) begin
            vld_reg[i] <= adv[i-1] | (vld_reg[i] & ~adv[i]);
         end
      end
   end

   // ---------------------------------------------------------------------
   // Stage 0: carry-save reduction in WIDTH+2 bits. For subtraction c is
   // inverted across the full extended width and the +1 goes into the free
   // LSB of the carry vector, so a+b+~c+1 wraps to a+b-c.
   // ---------------------------------------------------------------------
   logic [W2-1:0] a_x;
   logic [W2-1:0] b_x;
   logic [W2-1:0] c_x;
   logic [W2-2:0] maj;

   assign a_x = {2'b00, bus.a};
   assign b_x = {2'b00, bus.b};
   assign c_x = bus.sub ? ~{2'b00, bus.c} : {2'b00, bus.c};
   assign maj = (a_x[W2-2:0] & b_x[W2-2:0]) |
                (a_x[W2-2:0] & c_x[W2-2:0]) |
                (b_x[W2-2:0] & c_x[W2-2:0]);

   always_ff @(posedge clk) begin
      if (reset) begin
         s_reg[0]   <= '0;
         k_reg[0]   <= '0;
         res_reg[0] <= '0;
         cy_reg[0]  <= 1'b0;
      end else if (load0) begin
         s_reg[0]   <= a_x ^ b_x ^ c_x;
         k_reg[0]   <= {maj, bus.sub};
         res_reg[0] <= '0;
         cy_reg[0]  <= 1'b0;
      end
   end

   // ---------------------------------------------------------------------
   // Stages 1..NSEG: stage gi resolves segment gi-1. The last segment also
   // absorbs the two extension bits so the full WIDTH+2 result is exact.
   // ---------------------------------------------------------------------
   generate
      for (gi = 1; gi <= NSEG; gi++) begin : g_seg
         localparam int LO = (gi - 1) * CHUNK;
         localparam int HI = (gi == NSEG) ? (W2 - 1) : (gi * CHUNK - 1);
         localparam int SW = HI - LO + 1;

         logic [SW:0]   seg_sum;
         logic [W2-1:0] res_next;

         assign seg_sum = {1'b0, s_reg[gi-1][HI:LO]}
                        + {1'b0, k_reg[gi-1][HI:LO]}
                        + {{SW{1'b0}}, cy_reg[gi-1]};

         always_comb begin
            res_next        = res_reg[gi-1];
            res_next[HI:LO] = seg_sum[SW-1:0];
         end

         always_ff @(posedge clk) begin
            if (reset) begin
               s_reg[gi]   <= '0;
               k_reg[gi]   <= '0;
               res_reg[gi] <= '0;
               cy_reg[gi]  <= 1'b0;
            end else if (adv[gi-1]) begin
               s_reg[gi]   <= s_reg[gi-1];
               k_reg[gi]   <= k_reg[gi-1];
               res_reg[gi] <= res_next;
               cy_reg[gi]  <= seg_sum[SW];
            end
         end
      end
   endgenerate
endmodule

// File: tb/tb_pipe_adder3.sv
// ---------------------------------------------------------------------------
// tb_pipe_adder3
// Directed bench for pipe_adder3: reset state, latency, add/sub values,
// backpressure fill and drain, throughput, random ready toggling against a
// reference sum, mid-flight reset, and WIDTH=16 with CHUNK=4 and CHUNK=16.
// ---------------------------------------------------------------------------
module tb_pipe_adder3;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   pipe_adder3_if #(.WIDTH(8))  bus8 ();
   pipe_adder3_if #(.WIDTH(16)) bus16a ();
   pipe_adder3_if #(.WIDTH(16)) bus16b ();

   pipe_adder3 #(.WIDTH(8),  .CHUNK(4))  dut    (.clk(clk), .reset(reset), .bus(bus8));
   pipe_adder3 #(.WIDTH(16), .CHUNK(4))  dut16a (.clk(clk), .reset(reset), .bus(bus16a));
   pipe_adder3 #(.WIDTH(16), .CHUNK(16)) dut16b (.clk(clk), .reset(reset), .bus(bus16b));

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] c;
      logic       sub;
   } op_t;

   op_t        in_q[$];
   logic [9:0] exp_q[$];
   int n_checks = 0;
   int n_fail   = 0;
   int n_acc    = 0;
   int n_out    = 0;
   int rdy_mode = 1;   // 0: out_ready low, 1: high, 2: random

   function automatic logic [9:0] ref8(input op_t op);
      int r;
      r = int'(op.a) + int'(op.b);
      if (op.sub) r = r - int'(op.c);
      else        r = r + int'(op.c);
      return r[9:0];
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                        input logic sub);
      op_t op;
      op.a = a; op.b = b; op.c = c; op.sub = sub;
      in_q.push_back(op);
      exp_q.push_back(ref8(op));
   endtask

   // One clock of the 8-bit bench: drive the queue head, decide transfers
   // from the settled handshake, score any result leaving, then clock.
   task automatic step8();
      logic take;
      logic give;
      bus8.in_valid = (in_q.size() > 0);
      if (in_q.size() > 0) begin
         bus8.a   = in_q[0].a;
         bus8.b   = in_q[0].b;
         bus8.c   = in_q[0].c;
         bus8.sub = in_q[0].sub;
      end
      bus8.out_ready = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : (rdy_mode != 0);
      #1;
      take = bus8.in_valid & bus8.in_ready;
      give = bus8.out_valid & bus8.out_ready;
      if (give) begin
         n_out++;
         check("result_expected", 64'(exp_q.size() != 0), 64'd1);
         if (exp_q.size() != 0) check("foo_stream", 64'(bus8.foo), 64'(exp_q.pop_front()));
      end
      if (take) begin
         in_q.delete(0);
         n_acc++;
      end
      tick();
   endtask

   // Single operation on an empty 8-bit pipe; returns edges to out_valid.
   task automatic lat8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                       input logic sub, output int lat, output logic [9:0] res);
      bus8.a = a; bus8.b = b; bus8.c = c; bus8.sub = sub;
      bus8.in_valid = 1'b1; bus8.out_ready = 1'b1;
      #1;
      check("in_ready_idle8", 64'(bus8.in_ready), 64'd1);
      lat = 0;
      do begin
         tick();
         bus8.in_valid = 1'b0;
         lat++;
      end while (!bus8.out_valid && lat < 20);
      res = bus8.foo;
      tick();
   endtask

   task automatic lat16a(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c,
                         input logic sub, output int lat, output logic [17:0] res);
      bus16a.a = a; bus16a.b = b; bus16a.c = c; bus16a.sub = sub;
      bus16a.in_valid = 1'b1;
      lat = 0;
      do begin
         tick();
         bus16a.in_valid = 1'b0;
         lat++;
      end while (!bus16a.out_valid && lat < 20);
      res = bus16a.foo;
      tick();
   endtask

   task automatic lat16b(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c,
                         input logic sub, output int lat, output logic [17:0] res);
      bus16b.a = a; bus16b.b = b; bus16b.c = c; bus16b.sub = sub;
      bus16b.in_valid = 1'b1;
      lat = 0;
      do begin
         tick();
         bus16b.in_valid = 1'b0;
         lat++;
      end while (!bus16b.out_valid && lat < 20);
      res = bus16b.foo;
      tick();
   endtask

   initial begin
      int         lat;
      logic [9:0] r8;
      logic [17:0] r16;
      int         base_out;
      int         guard;

      // ---- reset state ----
      reset = 1'b1;
      bus8.in_valid = 1'b0;   bus8.out_ready = 1'b1;
      bus8.a = '0; bus8.b = '0; bus8.c = '0; bus8.sub = 1'b0;
      bus16a.in_valid = 1'b0; bus16a.out_ready = 1'b1;
      bus16a.a = '0; bus16a.b = '0; bus16a.c = '0; bus16a.sub = 1'b0;
      bus16b.in_valid = 1'b0; bus16b.out_ready = 1'b1;
      bus16b.a = '0; bus16b.b = '0; bus16b.c = '0; bus16b.sub = 1'b0;
      tick();
      tick();
      check("rst_out_valid", 64'(bus8.out_valid), 64'd0);
      check("rst_in_ready",  64'(bus8.in_ready),  64'd1);
      check("rst_foo",       64'(bus8.foo),       64'd0);
      check("rst_out_valid16", 64'(bus16a.out_valid), 64'd0);
      reset = 1'b0;
      tick();

      // ---- max add and latency ----
      lat8(8'd255, 8'd255, 8'd255, 1'b0, lat, r8);
      check("max_add_foo", 64'(r8), 64'h2FD);
      check("max_add_latency", 64'(lat), 64'd3);

      // ---- subtraction, negative results ----
      lat8(8'd5, 8'd3, 8'd10, 1'b1, lat, r8);
      check("sub_neg2_foo", 64'(r8), 64'h3FE);
      check("sub_neg2_latency", 64'(lat), 64'd3);
      lat8(8'd0, 8'd0, 8'd255, 1'b1, lat, r8);
      check("sub_neg255_foo", 64'(r8), 64'h301);
      lat8(8'd200, 8'd100, 8'd44, 1'b1, lat, r8);
      check("sub_pos_foo", 64'(r8), 64'd256);

      // ---- backpressure fill then drain ----
      rdy_mode = 0;
      n_acc = 0;
      base_out = n_out;
      for (int i = 1; i <= 5; i++) push8(8'(i), 8'(i), 8'(i), 1'b0);
      repeat (6) step8();
      check("fill_accepted", 64'(n_acc), 64'd3);
      check("fill_in_ready", 64'(bus8.in_ready), 64'd0);
      check("fill_out_valid", 64'(bus8.out_valid), 64'd1);
      check("fill_foo_hold", 64'(bus8.foo), 64'd3);
      rdy_mode = 1;
      guard = 0;
      while (exp_q.size() > 0 && guard < 40) begin step8(); guard++; end
      check("drain_count", 64'(n_out - base_out), 64'd5);
      check("drain_inputs_left", 64'(in_q.size()), 64'd0);

      // ---- throughput: one result per cycle ----
      for (int i = 0; i < 8; i++) push8(8'(i * 17), 8'(i * 3), 8'(i * 29), 1'(i % 2));
      guard = 0;
      while (exp_q.size() > 0 && guard < 50) begin step8(); guard++; end
      check("throughput_cycles", 64'(guard), 64'd11);

      // ---- random ready toggling ----
      rdy_mode = 2;
      n_acc = 0;
      base_out = n_out;
      for (int i = 0; i < 10000; i++)
         push8(8'($urandom), 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
      guard = 0;
      while (exp_q.size() > 0 && guard < 60000) begin step8(); guard++; end
      check("random_all_out", 64'(exp_q.size()), 64'd0);
      check("random_count", 64'(n_out - base_out), 64'd10000);
      check("random_accepted", 64'(n_acc), 64'd10000);

      // ---- reset with two items in flight ----
      rdy_mode = 1;
      push8(8'd9, 8'd9, 8'd9, 1'b0);
      push8(8'd1, 8'd2, 8'd3, 1'b0);
      step8();
      step8();
      reset = 1'b1;
      bus8.in_valid = 1'b1;
      bus8.a = 8'd77; bus8.b = 8'd77; bus8.c = 8'd77; bus8.sub = 1'b0;
      tick();
      check("midrst_out_valid", 64'(bus8.out_valid), 64'd0);
      check("midrst_in_ready",  64'(bus8.in_ready),  64'd1);
      check("midrst_foo",       64'(bus8.foo),       64'd0);
      reset = 1'b0;
      bus8.in_valid = 1'b0;
      in_q.delete();
      exp_q.delete();
      base_out = n_out;
      repeat (6) step8();
      check("midrst_no_stale", 64'(n_out - base_out), 64'd0);
      lat8(8'd100, 8'd50, 8'd25, 1'b0, lat, r8);
      check("postrst_foo", 64'(r8), 64'd175);
      check("postrst_latency", 64'(lat), 64'd3);

      // ---- WIDTH=16 sweep ----
      lat16a(16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b0, lat, r16);
      check("w16c4_foo", 64'(r16), 64'h2FFFD);
      check("w16c4_latency", 64'(lat), 64'd5);
      lat16a(16'h0000, 16'h0000, 16'hFFFF, 1'b1, lat, r16);
      check("w16c4_sub_foo", 64'(r16), 64'h30001);
      lat16b(16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b0, lat, r16);
      check("w16c16_foo", 64'(r16), 64'h2FFFD);
      check("w16c16_latency", 64'(lat), 64'd2);
      lat16b(16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b1, lat, r16);
      check("w16c16_sub_foo", 64'(r16), 64'h0FFFF);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
